bcd_countdown_timer: RTL and testbench
======================================

Name: bcd_countdown_timer

Overview:
- MM:SS countdown timer; sits directly downstream of the clock generator.
- Consumes its 1 s strobe (pulse1) and 1 ms strobe (pulse2), plus two raw push-buttons and a BCD preset.
- Drives a 4-digit multiplexed 7-seg interface (BCD + digit select) and status flags for the top level.

Parameters:
DEB_MS, 20, consecutive 1 ms ticks a button must be stable before a press is accepted
SYNC_STAGES, 2, flip-flop stages on each raw button input

Ports:
c50m  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high reset
pulse1  in  1  1 s strobe from clock generator; level, high several cycles per period
pulse2  in  1  1 ms strobe from clock generator; level, high several cycles per period
btn_start  in  1  raw start/pause button, active-high, asynchronous
btn_clear  in  1  raw clear button, active-high, asynchronous
preset_min  in  8  BCD minutes {tens,ones}
preset_sec  in  8  BCD seconds {tens,ones}
time_bcd  out  16  current value {min_t,min_o,sec_t,sec_o}
digit_bcd  out  4  BCD of currently scanned digit
digit_sel  out  4  one-hot active-low digit enable
running  out  1  high in RUN
done  out  1  high in DONE

Behaviour:
- Interface: one clock, c50m; reset is synchronous and active-high, named reset.
- All outputs and state are registered. Every output updates only on posedge c50m.
- Tick extraction:
  - sec_tick = pulse1 & ~pulse1_q; ms_tick = pulse2 & ~pulse2_q.
  - Each tick is exactly 1 cycle per period, however long the input level stays high.
- Buttons:
  - Pass through SYNC_STAGES flops.
  - Debounce counter samples only on ms_tick. Level is accepted after DEB_MS equal consecutive samples.
  - A 0->1 transition of the accepted level yields a 1-cycle press strobe (start_p, clear_p).
  - Holding a button yields exactly one strobe.
- Preset clamp (combinational):
  - Tens digit >5 becomes 5.
  - Ones digit >9 becomes 9.
- FSM states: IDLE, RUN, PAUSE, DONE. Reset -> IDLE.
  - IDLE: time_bcd follows clamped preset every cycle.
    - start_p with nonzero preset -> RUN.
    - start_p with preset 00:00 is ignored.
  - RUN: each sec_tick decrements by 1 s.
    - The first decrement occurs on the first sec_tick after entry; partial-second latency of 0..1 s is accepted.
    - Value reaching 00:00 -> DONE in the same cycle as the decrement.
    - start_p -> PAUSE.
  - PAUSE: value frozen; sec_tick ignored. start_p -> RUN.
  - DONE: value 00:00 held. start_p or clear_p -> IDLE.
  - clear_p from any state -> IDLE.
- Decrement arithmetic: BCD borrow chain.
  - sec_o 0 -> 9 with borrow; sec_t 0 -> 5 with borrow.
  - min_o 0 -> 9 with borrow; min_t decrements.
  - 10:00 -> 09:59; 01:00 -> 00:59.
  - Decrement is never applied at 00:00.
- Simultaneous events:
  - clear_p beats start_p.
  - In RUN, sec_tick with start_p: decrement is applied, then -> PAUSE.
  - In RUN, sec_tick reaching 00:00 with start_p: -> DONE.
- Display scan:
  - 2-bit index advances on ms_tick and wraps 3 -> 0.
  - Index 0 = sec_o, index 3 = min_t.
  - digit_sel = ~(1<<index); digit_bcd = selected nibble.
  - Both registered together, so there is no select/data skew.
- Reset values:
  - FSM IDLE; time_bcd 16'h0000 (loads preset the next cycle).
  - digit_sel 4'b1110; digit_bcd 0.
  - running 0; done 0.
  - Debounce and sync flops cleared; pulse*_q cleared.
- Reset mid-count: on the next edge, all of the above apply. No strobes are produced from pre-reset button state.

Optional Feature:
- Macro: DONE_BLINK_EN.
- Defined: in DONE, a blank flag toggles on each sec_tick, starting at 0 on DONE entry. While blank=1, digit_sel = 4'b1111. Leaving DONE clears blank.
- Undefined: no blank logic; digits are always driven in DONE.

Test Plan:
- Bench drives pulse1/pulse2 directly as short levels (10 cycles high) at compressed periods.
1. Reset mid-RUN at 01:23 -> next cycle: state IDLE, running 0, digit_sel 4'b1110; the following cycle time_bcd = preset.
2. Preset 01:00, press start, 2 sec ticks -> time_bcd 16'h0059 then 16'h0058; running 1. pulse1 held high 10 cycles decrements only once.
3. Preset 00:02, start, 2 sec ticks -> 0x0001 then 0x0000. done=1 and running=0 on the same edge as the 0x0000 update. Further ticks leave it unchanged. clear -> IDLE.
4. Button bounces (toggle every 3 ms for 15 ms, then stable high 25 ms) with DEB_MS=20 -> exactly one start_p; preset 00:00 plus start -> stays IDLE.
5. RUN at 10:00, sec_tick and start_p on the same cycle -> 0x0959, state PAUSE. 3 ticks leave 0x0959 unchanged. start -> RUN. start and clear on the same cycle -> IDLE.
6. Scan with time 12:34 -> per ms_tick (digit_sel, digit_bcd): (1110,4), (1101,3), (1011,2), (0111,1), then wrap. With DONE_BLINK_EN in DONE -> digit_sel 1111 on alternate seconds.

Source files
------------

// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer with debounced start/clear buttons and a 4-digit multiplexed display scan.
// Optional: define DONE_BLINK_EN to blank the display on alternate seconds while in DONE.
module bcd_countdown_timer #(
    parameter int DEB_MS      = 20,
    parameter int SYNC_STAGES = 2
) (
    input  logic        c50m,
    input  logic        reset,
    input  logic        pulse1,
    input  logic        pulse2,
    input  logic        btn_start,
    input  logic        btn_clear,
    input  logic [7:0]  preset_min,
    input  logic [7:0]  preset_sec,
    output logic [15:0] time_bcd,
    output logic [3:0]  digit_bcd,
    output logic [3:0]  digit_sel,
    output logic        running,
    output logic        done
);
    localparam int CW = $clog2(DEB_MS + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_MS - 1);
    localparam logic [CW-1:0] DEB_MAX  = CW'(DEB_MS);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
    state_t state, next_state;

    logic                   pulse1_q, pulse2_q;
    logic                   sec_tick, ms_tick;
    logic [SYNC_STAGES-1:0] sync_start, sync_clear;
    logic [1:0]             raw_s, cand, acc, acc_q;
    logic [CW-1:0]          cnt [2];
    logic                   start_p, clear_p;
    logic [15:0]            preset_clamped, dec_time, next_time;
    logic                   tick_dec;
    logic [1:0]             scan_idx, idx_next;
    logic [3:0]             scan_nib, sel_next;

    assign sec_tick = pulse1 & ~pulse1_q;
    assign ms_tick  = pulse2 & ~pulse2_q;

    always_ff @(posedge c50m) begin
        if (reset) begin
            pulse1_q   <= 1'b0;
            pulse2_q   <= 1'b0;
            sync_start <= '0;
            sync_clear <= '0;
        end else begin
            pulse1_q      <= pulse1;
            pulse2_q      <= pulse2;
            sync_start[0] <= btn_start;
            sync_clear[0] <= btn_clear;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_start[i] <= sync_start[i-1];
                sync_clear[i] <= sync_clear[i-1];
            end
        end
    end

    assign raw_s = {sync_clear[SYNC_STAGES-1], sync_start[SYNC_STAGES-1]};

    // Any sample differing from the candidate restarts the stability run at one sample.
    always_ff @(posedge c50m) begin
        if (reset) begin
            cand  <= '0;
            acc   <= '0;
            acc_q <= '0;
            for (int b = 0; b < 2; b++) cnt[b] <= '0;
        end else begin
            acc_q <= acc;
            if (ms_tick) begin
                for (int b = 0; b < 2; b++) begin
                    if (raw_s[b] != cand[b]) begin
                        cand[b] <= raw_s[b];
                        cnt[b]  <= CW'(1);
                    end else if (cnt[b] != DEB_MAX) begin
                        cnt[b] <= cnt[b] + CW'(1);
                        if (cnt[b] == DEB_LAST) acc[b] <= cand[b];
                    end
                end
            end
        end
    end

    assign start_p = acc[0] & ~acc_q[0];
    assign clear_p = acc[1] & ~acc_q[1];

    assign preset_clamped[15:12] = (preset_min[7:4] > 4'd5) ? 4'd5 : preset_min[7:4];
    assign preset_clamped[11:8]  = (preset_min[3:0] > 4'd9) ? 4'd9 : preset_min[3:0];
    assign preset_clamped[7:4]   = (preset_sec[7:4] > 4'd5) ? 4'd5 : preset_sec[7:4];
    assign preset_clamped[3:0]   = (preset_sec[3:0] > 4'd9) ? 4'd9 : preset_sec[3:0];

    always_comb begin
        dec_time = time_bcd;
        if (time_bcd[3:0] != 4'd0) begin
            dec_time[3:0] = time_bcd[3:0] - 4'd1;
        end else begin
            dec_time[3:0] = 4'd9;
            if (time_bcd[7:4] != 4'd0) begin
                dec_time[7:4] = time_bcd[7:4] - 4'd1;
            end else begin
                dec_time[7:4] = 4'd5;
                if (time_bcd[11:8] != 4'd0) begin
                    dec_time[11:8] = time_bcd[11:8] - 4'd1;
                end else begin
                    dec_time[11:8]  = 4'd9;
                    dec_time[15:12] = time_bcd[15:12] - 4'd1;
                end
            end
        end
    end

    assign tick_dec = sec_tick && (time_bcd != 16'h0000);

    always_comb begin
        next_state = state;
        next_time  = time_bcd;
        case (state)
            IDLE: begin
                next_time = preset_clamped;
                if (start_p && !clear_p && preset_clamped != 16'h0000) next_state = RUN;
            end
            RUN: begin
                if (clear_p) begin
                    next_state = IDLE;
                end else begin
                    if (tick_dec) next_time = dec_time;
                    if (tick_dec && dec_time == 16'h0000) next_state = DONE;
                    else if (start_p)                      next_state = PAUSE;
                end
            end
            PAUSE: begin
                if (clear_p)      next_state = IDLE;
                else if (start_p) next_state = RUN;
            end
            DONE: begin
                next_time = 16'h0000;
                if (clear_p || start_p) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge c50m) begin
        if (reset) begin
            state    <= IDLE;
            time_bcd <= 16'h0000;
            running  <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= next_state;
            time_bcd <= next_time;
            running  <= (next_state == RUN);
            done     <= (next_state == DONE);
        end
    end

    assign idx_next = ms_tick ? scan_idx + 2'd1 : scan_idx;

    always_comb begin
        scan_nib = time_bcd[3:0];
        case (idx_next)
            2'd0: scan_nib = time_bcd[3:0];
            2'd1: scan_nib = time_bcd[7:4];
            2'd2: scan_nib = time_bcd[11:8];
            2'd3: scan_nib = time_bcd[15:12];
            default: scan_nib = time_bcd[3:0];
        endcase
    end

`ifdef DONE_BLINK_EN
    logic blank;

    always_ff @(posedge c50m) begin
        if (reset)                                    blank <= 1'b0;
        else if (state == DONE && next_state == DONE) blank <= sec_tick ? ~blank : blank;
        else                                          blank <= 1'b0;
    end

    assign sel_next = blank ? 4'b1111 : ~(4'b0001 << idx_next);
`else
    assign sel_next = ~(4'b0001 << idx_next);
`endif

    // Select and data are loaded on the same edge so the display never shows a mismatched pair.
    always_ff @(posedge c50m) begin
        if (reset) begin
            scan_idx  <= 2'd0;
            digit_sel <= 4'b1110;
            digit_bcd <= 4'd0;
        end else begin
            scan_idx  <= idx_next;
            digit_sel <= sel_next;
            digit_bcd <= scan_nib;
        end
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer: table-driven clamp/scan vectors plus multi-cycle sequences.
// Expectations flow through a scoreboard queue; DONE_BLINK_EN selects the blink expectation.
module tb_bcd_countdown_timer;
    localparam int DEB_MS = 20;

    logic        c50m = 1'b0;
    logic        reset, pulse1, pulse2, btn_start, btn_clear;
    logic [7:0]  preset_min, preset_sec;
    logic [15:0] time_bcd;
    logic [3:0]  digit_bcd, digit_sel;
    logic        running, done;

    int vectors     = 0;
    int miscompares = 0;
    int startCount  = 0;

    typedef struct {
        string       name;
        logic [15:0] exp;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [7:0]  pmin;
        logic [7:0]  psec;
        logic [15:0] exp;
    } clamp_vec_t;

    bcd_countdown_timer #(.DEB_MS(DEB_MS), .SYNC_STAGES(2)) dut (
        .c50m       (c50m),
        .reset      (reset),
        .pulse1     (pulse1),
        .pulse2     (pulse2),
        .btn_start  (btn_start),
        .btn_clear  (btn_clear),
        .preset_min (preset_min),
        .preset_sec (preset_sec),
        .time_bcd   (time_bcd),
        .digit_bcd  (digit_bcd),
        .digit_sel  (digit_sel),
        .running    (running),
        .done       (done)
    );

    always #5 c50m = ~c50m;

    always @(posedge c50m) if (dut.start_p) startCount <= startCount + 1;

    task automatic cycles(input int n);
        repeat (n) @(negedge c50m);
    endtask

    task automatic expectVal(input string name, input logic [15:0] exp);
        exp_t e;
        e.name = name;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input logic [15:0] actual);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_empty: got %h with no expectation queued", actual);
        end else begin
            e = sb.pop_front();
            if (actual !== e.exp) begin
                miscompares++;
                $display("[TB] FAIL %s: got %h expected %h", e.name, actual, e.exp);
            end
        end
    endtask

    task automatic chk(input string name, input logic [15:0] actual, input logic [15:0] exp);
        expectVal(name, exp);
        checkOutput(actual);
    endtask

    task automatic applyStimulus(input logic [7:0] pm, input logic [7:0] ps);
        preset_min = pm;
        preset_sec = ps;
        cycles(2);
    endtask

    task automatic msTicks(input int n);
        for (int i = 0; i < n; i++) begin
            pulse2 = 1'b1;
            cycles(10);
            pulse2 = 1'b0;
            cycles(10);
        end
    endtask

    task automatic secTick();
        pulse1 = 1'b1;
        cycles(10);
        pulse1 = 1'b0;
        cycles(10);
    endtask

    task automatic press(input logic s, input logic c);
        btn_start = s;
        btn_clear = c;
        msTicks(DEB_MS + 2);
        btn_start = 1'b0;
        btn_clear = 1'b0;
        msTicks(DEB_MS + 2);
    endtask

    // Holds start until its strobe appears, then raises pulse1 so the sec tick lands on the same edge.
    task automatic pressWithSecTick();
        bit fired;
        fired = 1'b0;
        btn_start = 1'b1;
        for (int c = 0; c < 1000 && !fired; c++) begin
            if (dut.start_p) begin
                pulse1 = 1'b1;
                fired  = 1'b1;
            end else begin
                pulse2 = ((c % 20) < 10);
                cycles(1);
            end
        end
        if (!fired) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL aligned_press_timeout: got no start strobe within 1000 cycles, required one");
        end
        cycles(1);
        pulse2 = 1'b0;
        cycles(9);
        pulse1    = 1'b0;
        btn_start = 1'b0;
        msTicks(DEB_MS + 2);
    endtask

    initial begin
        clamp_vec_t clampTab[7];
        logic [7:0] scanTab[5];
        logic       blinkOn;
        int         base;

`ifdef DONE_BLINK_EN
        blinkOn = 1'b1;
`else
        blinkOn = 1'b0;
`endif
        clampTab[0] = '{8'h12, 8'h34, 16'h1234};
        clampTab[1] = '{8'h99, 8'h99, 16'h5959};
        clampTab[2] = '{8'h6A, 8'h7F, 16'h5959};
        clampTab[3] = '{8'h00, 8'h00, 16'h0000};
        clampTab[4] = '{8'h59, 8'h59, 16'h5959};
        clampTab[5] = '{8'h09, 8'h60, 16'h0950};
        clampTab[6] = '{8'hF0, 8'h0F, 16'h5009};
        scanTab = '{8'hE4, 8'hD3, 8'hB2, 8'h71, 8'hE4};

        reset = 1'b1; pulse1 = 1'b0; pulse2 = 1'b0;
        btn_start = 1'b0; btn_clear = 1'b0;
        preset_min = 8'h12; preset_sec = 8'h34;
        cycles(3);
        chk("reset_time",    time_bcd,           16'h0000);
        chk("reset_sel",     {12'd0, digit_sel}, 16'h000E);
        chk("reset_bcd",     {12'd0, digit_bcd}, 16'h0000);
        chk("reset_running", {15'd0, running},   16'h0000);
        chk("reset_done",    {15'd0, done},      16'h0000);
        reset = 1'b0;
        cycles(1);
        chk("idle_load_preset", time_bcd, 16'h1234);
        cycles(1);

        $display("[TB] display scan at 12:34");
        for (int i = 0; i < 5; i++) begin
            expectVal($sformatf("scan_%0d", i), {8'h00, scanTab[i]});
            checkOutput({8'h00, digit_sel, digit_bcd});
            msTicks(1);
        end

        $display("[TB] preset clamp table");
        for (int i = 0; i < 7; i++) begin
            expectVal($sformatf("clamp_%0d", i), clampTab[i].exp);
            applyStimulus(clampTab[i].pmin, clampTab[i].psec);
            checkOutput(time_bcd);
        end

        $display("[TB] 01:00 countdown");
        applyStimulus(8'h01, 8'h00);
        press(1'b1, 1'b0);
        chk("t2_running",   {15'd0, running}, 16'h0001);
        chk("t2_hold",      time_bcd,         16'h0100);
        secTick();
        chk("t2_first_dec", time_bcd,         16'h0059);
        secTick();
        chk("t2_second_dec", time_bcd,        16'h0058);
        chk("t2_still_run", {15'd0, running}, 16'h0001);
        press(1'b0, 1'b1);
        chk("t2_clear_idle", {15'd0, running}, 16'h0000);

        $display("[TB] 00:02 to DONE");
        applyStimulus(8'h00, 8'h02);
        press(1'b1, 1'b0);
        chk("t3_running", {15'd0, running}, 16'h0001);
        secTick();
        chk("t3_0001", time_bcd, 16'h0001);
        pulse1 = 1'b1;
        cycles(1);
        chk("t3_0000",         time_bcd,         16'h0000);
        chk("t3_done_edge",    {15'd0, done},    16'h0001);
        chk("t3_running_edge", {15'd0, running}, 16'h0000);
        cycles(9);
        pulse1 = 1'b0;
        cycles(10);
        secTick();
        chk("t3_done_hold",   time_bcd,                        16'h0000);
        chk("t3_blink_on",    {15'd0, (digit_sel == 4'b1111)}, {15'd0, blinkOn});
        secTick();
        chk("t3_blink_off",   {15'd0, (digit_sel == 4'b1111)}, 16'h0000);
        chk("t3_done_still",  {15'd0, done},                   16'h0001);
        press(1'b0, 1'b1);
        chk("t3_clear_done",  {15'd0, done},    16'h0000);
        chk("t3_clear_run",   {15'd0, running}, 16'h0000);
        chk("t3_idle_preset", time_bcd,         16'h0002);

        $display("[TB] bouncing start with 00:00 preset");
        applyStimulus(8'h00, 8'h00);
        base = startCount;
        for (int i = 0; i < 5; i++) begin
            btn_start = ~btn_start;
            msTicks(3);
        end
        btn_start = 1'b1;
        msTicks(25);
        btn_start = 1'b0;
        msTicks(DEB_MS + 2);
        chk("t4_one_strobe", 16'(startCount - base), 16'h0001);
        chk("t4_zero_idle",  {15'd0, running},       16'h0000);
        chk("t4_zero_time",  time_bcd,               16'h0000);

        $display("[TB] 10:00 tick with pause");
        applyStimulus(8'h10, 8'h00);
        press(1'b1, 1'b0);
        chk("t5_running", {15'd0, running}, 16'h0001);
        pressWithSecTick();
        chk("t5_0959",     time_bcd,         16'h0959);
        chk("t5_paused",   {15'd0, running}, 16'h0000);
        chk("t5_not_done", {15'd0, done},    16'h0000);
        for (int i = 0; i < 3; i++) secTick();
        chk("t5_frozen", time_bcd, 16'h0959);
        press(1'b1, 1'b0);
        chk("t5_resume",      {15'd0, running}, 16'h0001);
        chk("t5_resume_time", time_bcd,         16'h0959);
        press(1'b1, 1'b1);
        chk("t5_clear_wins", {15'd0, running}, 16'h0000);
        chk("t5_idle_time",  time_bcd,         16'h1000);

        $display("[TB] reset mid-run");
        applyStimulus(8'h01, 8'h23);
        press(1'b1, 1'b0);
        chk("t1_running", {15'd0, running}, 16'h0001);
        reset = 1'b1;
        cycles(1);
        chk("t1_rst_running", {15'd0, running},   16'h0000);
        chk("t1_rst_done",    {15'd0, done},      16'h0000);
        chk("t1_rst_sel",     {12'd0, digit_sel}, 16'h000E);
        chk("t1_rst_time",    time_bcd,           16'h0000);
        reset = 1'b0;
        cycles(1);
        chk("t1_preset", time_bcd, 16'h0123);
        msTicks(DEB_MS + 2);
        chk("t1_no_strobe_run", {15'd0, running}, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
